// File: rtl/mems_spi_master_if.sv
// mems_spi_master_if: request/response handshake plus SPI pins of mems_spi_master
// master modport (the SPI engine): in in_valid/in_data/in_cs/miso; out in_ready/sck/mosi/cs_n/busy/out_valid/out_data
// slave modport (the requester/bench side): the mirror image
interface mems_spi_master_if #(
  parameter int DATA_W = 24,
  parameter int NUM_CS = 4,
  parameter int CSW    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CSW-1:0]    in_cs;
  logic              miso;
  logic              sck;
  logic              mosi;
  logic [NUM_CS-1:0] cs_n;
  logic              busy;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  modport master (input in_valid, in_data, in_cs, miso,
                  output in_ready, sck, mosi, cs_n, busy, out_valid, out_data);
  modport slave (output in_valid, in_data, in_cs, miso,
                 input in_ready, sck, mosi, cs_n, busy, out_valid, out_data);
endinterface

// File: rtl/mems_spi_master.sv
// mems_spi_master: single-word SPI master with chip-select decode, CPOL/CPHA modes and inter-transfer gap
// ports: clk, rst (sync, active-high), bus (mems_spi_master_if.master: request handshake, SPI pins, result word)
module mems_spi_master #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 16,
  parameter int NUM_CS  = 4,
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int CS_GAP  = 1
) (
  input logic clk,
  input logic rst,
  mems_spi_master_if.master bus
);
  localparam int H  = CLK_DIV / 2;
  localparam int BW = $clog2(DATA_W) + 1;
  localparam int CW = $clog2(CLK_DIV * (CS_GAP + 1) + 1);
  localparam logic [NUM_CS-1:0] ONE_CS = NUM_CS'(1);
  typedef enum logic [2:0] {IDLE, SETUP, TRANSFER, HOLD, GAP} state_t;
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [BW-1:0] r_bit, w_bit;
  logic [DATA_W-1:0] r_tx, r_rx, r_out_data;
  logic [NUM_CS-1:0] r_cs_n = '1;
  logic r_sck, r_out_valid, w_end, w_acc;
  assign w_acc = (r_state == IDLE) && bus.in_valid;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt + CW'(1);
    w_bit = r_bit;
    w_end = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        w_state = bus.in_valid ? SETUP : IDLE;
      end
      SETUP: if (r_cnt == CW'(H - 1)) begin
        w_state = TRANSFER;
        w_cnt = '0;
      end
      TRANSFER: if (r_cnt == CW'(CLK_DIV - 1)) begin
        w_cnt = '0;
        w_bit = (r_bit == BW'(DATA_W - 1)) ? '0 : r_bit + BW'(1);
        w_state = (r_bit == BW'(DATA_W - 1)) ? HOLD : TRANSFER;
      end
      HOLD: if (r_cnt == CW'(H - 1)) begin
        w_end = 1'b1;
        w_cnt = '0;
        w_state = (CS_GAP == 0) ? IDLE : GAP;
      end
      GAP: if (r_cnt == CW'(CLK_DIV * CS_GAP - 1)) begin
        w_state = IDLE;
        w_cnt = '0;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_bit <= w_bit;
    end
  end
  // sck is registered from the next state so it lines up with the counters;
  // both modes sample miso one cycle after the mid-period sck edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs_n <= '1;
      r_sck <= CPOL[0];
      r_tx <= '0;
      r_rx <= '0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_valid <= w_end;
      r_sck <= (w_state == TRANSFER) ? (CPOL[0] ^ CPHA[0] ^ (w_cnt >= CW'(H))) : CPOL[0];
      if (w_acc) begin
        r_cs_n <= ~(ONE_CS << bus.in_cs);
        r_tx <= bus.in_data;
      end else if (w_end) begin
        r_cs_n <= '1;
        r_tx <= '0;
        r_out_data <= r_rx;
      end else if (r_state == TRANSFER && w_state == TRANSFER && w_cnt == '0) begin
        r_tx <= r_tx << 1;
      end
      if (r_state == TRANSFER && r_cnt == CW'(H))
        r_rx <= {r_rx[DATA_W-2:0], bus.miso};
    end
  end
  assign bus.in_ready = (r_state == IDLE);
  assign bus.busy = (r_state != IDLE);
  assign bus.sck = r_sck;
  assign bus.mosi = r_tx[DATA_W-1];
  assign bus.cs_n = r_cs_n;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data = r_out_data;
endmodule

// File: tb/tb_mems_spi_master.sv
// tb_mems_spi_master: scoreboard bench for three mems_spi_master configurations
module tb_mems_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mems_spi_master_if #(.DATA_W(24), .NUM_CS(4)) b1();
  mems_spi_master_if #(.DATA_W(16), .NUM_CS(4)) b2();
  mems_spi_master_if #(.DATA_W(24), .NUM_CS(3)) b3();
  mems_spi_master u1 (.clk(clk), .rst(rst), .bus(b1));
  mems_spi_master #(.DATA_W(16), .CLK_DIV(4), .CPOL(1), .CPHA(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
  mems_spi_master #(.NUM_CS(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  logic miso2 = 1'b1;
  assign b1.miso = b1.mosi;
  assign b2.miso = miso2;
  assign b3.miso = 1'b0;
  task automatic chk(input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s (cycle %0d)", msg, cyc);
    end
  endtask
  typedef struct {logic [23:0] d; int due;} e1_t;
  e1_t q1[$];
  int idle1 = 0, last_acc = -1, pulses1 = 0, high_run = 0;
  bit cont_mode = 0, rst_prev = 0, run_ok = 0, cs_pend = 0;
  logic [23:0] cap1 = '0;
  logic [3:0] exp_cs1 = '0;
  logic prev_sck1 = 1'b0;
  initial forever begin
    e1_t e;
    @(negedge clk);
    if (rst) begin
      idle1 = cyc + 1;
      q1.delete();
      run_ok = 0;
      cs_pend = 0;
    end else begin
      if (rst_prev)
        chk(b1.cs_n == 4'hF && !b1.sck && !b1.mosi && !b1.out_valid && b1.out_data == '0,
            $sformatf("reset_state1 cs_n=%h sck=%b mosi=%b vld=%b data=%h required f/0/0/0/0",
                      b1.cs_n, b1.sck, b1.mosi, b1.out_valid, b1.out_data));
      chk(b1.in_ready == (cyc >= idle1) && b1.busy == (cyc < idle1),
          $sformatf("ready1 ready=%b busy=%b required ready=%b", b1.in_ready, b1.busy, cyc >= idle1));
      if (cs_pend) begin
        chk(b1.cs_n == exp_cs1, $sformatf("cs_assert1 cs_n=%b required %b", b1.cs_n, exp_cs1));
        cs_pend = 0;
      end
      if (b1.sck && !prev_sck1 && !(&b1.cs_n)) begin
        pulses1++;
        cap1 = {cap1[22:0], b1.mosi};
      end
      if (b1.out_valid) begin
        if (q1.size() == 0) chk(1'b0, "spurious_valid1 out_valid=1 required 0");
        else begin
          e = q1.pop_front();
          chk(b1.out_data == e.d, $sformatf("data1 got=%h required %h", b1.out_data, e.d));
          chk(cyc == e.due, $sformatf("valid_time1 got=%0d required %0d", cyc, e.due));
          chk(pulses1 == 24 && cap1 == e.d,
              $sformatf("mosi1 pulses=%0d bits=%h required 24 %h", pulses1, cap1, e.d));
        end
      end
      if (b1.in_valid && b1.in_ready) begin
        q1.push_back('{b1.in_data, cyc + 401});
        idle1 = cyc + 417;
        exp_cs1 = 4'hF ^ (4'h1 << b1.in_cs);
        cs_pend = 1;
        pulses1 = 0;
        cap1 = '0;
        if (cont_mode && last_acc >= 0)
          chk(cyc - last_acc == 417, $sformatf("accept_spacing got=%0d required 417", cyc - last_acc));
        last_acc = cyc;
      end
      if (&b1.cs_n) high_run++;
      else begin
        if (run_ok && high_run > 0)
          chk(high_run >= 16, $sformatf("cs_gap1 got=%0d required >=16", high_run));
        run_ok = 1;
        high_run = 0;
      end
    end
    chk($countones(~b1.cs_n) <= 1, $sformatf("one_cs1 cs_n=%b required at most one low", b1.cs_n));
    if (&b1.cs_n)
      chk(!b1.sck && !b1.mosi, $sformatf("idle_pins1 sck=%b mosi=%b required 0 0", b1.sck, b1.mosi));
    prev_sck1 = b1.sck;
    rst_prev = rst;
  end
  typedef struct {logic [15:0] d; int due;} e2_t;
  e2_t q2[$];
  int idle2 = 0, k2 = 0;
  logic [15:0] w2 = '1, w2_cur = '1;
  logic prev_sck2 = 1'b1;
  initial forever begin
    e2_t e;
    @(negedge clk);
    if (rst) idle2 = cyc + 1;
    else begin
      chk(b2.in_ready == (cyc >= idle2) && b2.busy == (cyc < idle2),
          $sformatf("ready2 ready=%b busy=%b required ready=%b", b2.in_ready, b2.busy, cyc >= idle2));
      if (!b2.sck && prev_sck2 && !(&b2.cs_n)) begin
        miso2 = w2_cur[15];
        w2_cur = w2_cur << 1;
        k2++;
      end
      if (b2.out_valid) begin
        if (q2.size() == 0) chk(1'b0, "spurious_valid2 out_valid=1 required 0");
        else begin
          e = q2.pop_front();
          chk(b2.out_data == e.d && cyc == e.due && k2 == 16,
              $sformatf("result2 data=%h cyc=%0d pulses=%0d required %h %0d 16", b2.out_data, cyc, k2, e.d, e.due));
        end
      end
      if (b2.in_valid && b2.in_ready) begin
        q2.push_back('{w2, cyc + 69});
        w2_cur = w2;
        k2 = 0;
        idle2 = cyc + 73;
      end
      if (&b2.cs_n)
        chk(b2.sck && !b2.mosi, $sformatf("idle_pins2 sck=%b mosi=%b required 1 0", b2.sck, b2.mosi));
      chk($countones(~b2.cs_n) <= 1, $sformatf("one_cs2 cs_n=%b required at most one low", b2.cs_n));
    end
    prev_sck2 = b2.sck;
  end
  typedef struct {int due; logic [2:0] cs;} e3_t;
  e3_t q3[$];
  int idle3 = 0, acc3 = 0, pulses3 = 0;
  logic prev_sck3 = 1'b0;
  initial forever begin
    e3_t e;
    @(negedge clk);
    if (rst) idle3 = cyc + 1;
    else begin
      chk(b3.in_ready == (cyc >= idle3) && b3.busy == (cyc < idle3),
          $sformatf("ready3 ready=%b busy=%b required ready=%b", b3.in_ready, b3.busy, cyc >= idle3));
      if (cyc >= idle3) chk(!b3.mosi, "idle_mosi3 mosi=1 required 0");
      if (b3.sck && !prev_sck3) pulses3++;
      if (q3.size() > 0 && cyc > acc3 && cyc < q3[0].due)
        chk(b3.cs_n == q3[0].cs, $sformatf("cs3 cs_n=%b required %b", b3.cs_n, q3[0].cs));
      if (b3.out_valid) begin
        if (q3.size() == 0) chk(1'b0, "spurious_valid3 out_valid=1 required 0");
        else begin
          e = q3.pop_front();
          chk(cyc == e.due && pulses3 == 24 && b3.out_data == '0,
              $sformatf("result3 cyc=%0d pulses=%0d data=%h required %0d 24 0", cyc, pulses3, b3.out_data, e.due));
        end
      end
      if (b3.in_valid && b3.in_ready) begin
        q3.push_back('{cyc + 401, (b3.in_cs < 2'd3) ? 3'b111 ^ (3'b001 << b3.in_cs) : 3'b111});
        acc3 = cyc;
        pulses3 = 0;
        idle3 = cyc + 417;
      end
      chk($countones(~b3.cs_n) <= 1, $sformatf("one_cs3 cs_n=%b required at most one low", b3.cs_n));
    end
    prev_sck3 = b3.sck;
  end
  task automatic send1(input logic [23:0] d, input logic [1:0] cs);
    int n;
    @(posedge clk); #1;
    b1.in_data = d;
    b1.in_cs = cs;
    b1.in_valid = 1'b1;
    for (n = 0; n < 2000 && !b1.in_ready; n++) begin @(posedge clk); #1; end
    if (n == 2000) chk(1'b0, "accept_timeout1 in_ready=0 required 1");
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
  endtask
  task automatic send2(input logic [15:0] w, input logic [1:0] cs);
    int n;
    @(posedge clk); #1;
    w2 = w;
    b2.in_data = 16'($urandom);
    b2.in_cs = cs;
    b2.in_valid = 1'b1;
    for (n = 0; n < 1000 && !b2.in_ready; n++) begin @(posedge clk); #1; end
    if (n == 1000) chk(1'b0, "accept_timeout2 in_ready=0 required 1");
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
  endtask
  task automatic send3(input logic [1:0] cs);
    int n;
    @(posedge clk); #1;
    b3.in_data = 24'($urandom);
    b3.in_cs = cs;
    b3.in_valid = 1'b1;
    for (n = 0; n < 2000 && !b3.in_ready; n++) begin @(posedge clk); #1; end
    if (n == 2000) chk(1'b0, "accept_timeout3 in_ready=0 required 1");
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
  endtask
  initial begin
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_cs = '0;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_cs = '0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.in_cs = '0;
    #1 chk(b1.cs_n == 4'hF, $sformatf("powerup_cs1 cs_n=%b required 1111", b1.cs_n));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send2(16'hFFFF, 2'd1);
    send2(16'($urandom), 2'd3);
    send2(16'($urandom), 2'd0);
    send3(2'd3);
    send3(2'd1);
    send1(24'hA5C3F0, 2'd2);
    repeat (8) send1(24'($urandom), 2'($urandom));
    for (int n = 0; n < 2000 && !b1.in_ready; n++) begin @(posedge clk); #1; end
    last_acc = -1;
    cont_mode = 1;
    b1.in_valid = 1'b1;
    repeat (3 * 417 + 5) begin
      b1.in_data = 24'($urandom);
      b1.in_cs = 2'($urandom);
      @(posedge clk); #1;
    end
    b1.in_valid = 1'b0;
    cont_mode = 0;
    send1(24'($urandom), 2'($urandom));
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send1(24'($urandom), 2'($urandom));
    send1(24'($urandom), 2'($urandom));
    repeat (450) @(posedge clk);
    #1 chk(q1.size() == 0 && q2.size() == 0 && q3.size() == 0,
           $sformatf("drain pending=%0d/%0d/%0d required 0/0/0", q1.size(), q2.size(), q3.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
